// File: rtl/lcd_ctrl.sv
// 8x8 8-bit image engine: loads IROM into a pixel buffer, applies 2x2 window
// commands (shift/average/mirror) and dumps the buffer to IRB on Write.
module lcd_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] cmd,
  input  logic       cmd_valid,
  input  logic [7:0] IROM_Q,
  output logic       IROM_EN,
  output logic [5:0] IROM_A,
  output logic       IRB_RW,
  output logic [7:0] IRB_D,
  output logic [5:0] IRB_A,
  output logic       busy,
  output logic       done
);

  typedef enum logic [2:0] {
    S_LOAD  = 3'd0,
    S_IDLE  = 3'd1,
    S_EXEC  = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t     state_q, state_d;
  logic [6:0] cnt_q, cnt_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       irom_en_q, irom_en_d;
  logic [5:0] irom_a_q, irom_a_d;
  logic       irb_rw_q, irb_rw_d;
  logic [5:0] irb_a_q, irb_a_d;
  logic [7:0] irb_d_q, irb_d_d;
  logic [3:0] cmd_q, cmd_d;
  logic [2:0] px_q, px_d;
  logic [2:0] py_q, py_d;
  logic [7:0] pix_q [64];
  logic [7:0] pix_d [64];

  logic       accept;
  logic [2:0] xm1, ym1;
  logic [5:0] a00, a01, a10, a11;
  logic [6:0] cap_idx;
  logic [7:0] win_avg;

  function automatic logic [7:0] avg4(input logic [7:0] p0, input logic [7:0] p1,
                                      input logic [7:0] p2, input logic [7:0] p3);
    logic [9:0] sum;
    sum = {2'b00, p0} + {2'b00, p1} + {2'b00, p2} + {2'b00, p3};
    return sum[9:2];
  endfunction

  assign accept  = cmd_valid && !busy_q;
  assign xm1     = px_q - 3'd1;
  assign ym1     = py_q - 3'd1;
  // row*8+col is just {row, col}
  assign a00     = {ym1, xm1};
  assign a01     = {ym1, px_q};
  assign a10     = {py_q, xm1};
  assign a11     = {py_q, px_q};
  // IROM is a registered read, so data for address k arrives two edges after it is issued
  assign cap_idx = cnt_q - 7'd2;
  assign win_avg = avg4(pix_q[a00], pix_q[a01], pix_q[a10], pix_q[a11]);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_LOAD;
      cnt_q     <= 7'd0;
      busy_q    <= 1'b1;
      done_q    <= 1'b0;
      irom_en_q <= 1'b1;
      irom_a_q  <= 6'd0;
      irb_rw_q  <= 1'b1;
      irb_a_q   <= 6'd0;
      irb_d_q   <= 8'd0;
      cmd_q     <= 4'd0;
      px_q      <= 3'd4;
      py_q      <= 3'd4;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      irom_en_q <= irom_en_d;
      irom_a_q  <= irom_a_d;
      irb_rw_q  <= irb_rw_d;
      irb_a_q   <= irb_a_d;
      irb_d_q   <= irb_d_d;
      cmd_q     <= cmd_d;
      px_q      <= px_d;
      py_q      <= py_d;
    end
  end

  always_ff @(posedge clk) begin
    pix_q <= pix_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_LOAD:  if (cnt_q == 7'd65) state_d = S_IDLE;
      S_IDLE:  if (accept) state_d = (cmd == 4'd0) ? S_WRITE : S_EXEC;
      S_EXEC:  state_d = S_IDLE;
      S_WRITE: if (cnt_q == 7'd63) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_LOAD;
    endcase
  end

  always_comb begin
    cnt_d     = cnt_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    irom_en_d = 1'b1;
    irom_a_d  = irom_a_q;
    irb_rw_d  = 1'b1;
    irb_a_d   = irb_a_q;
    irb_d_d   = irb_d_q;
    cmd_d     = cmd_q;
    px_d      = px_q;
    py_d      = py_q;
    pix_d     = pix_q;
    case (state_q)
      S_LOAD: begin
        cnt_d = cnt_q + 7'd1;
        if (cnt_q < 7'd64) begin
          irom_en_d = 1'b0;
          irom_a_d  = cnt_q[5:0];
        end
        if (cnt_q >= 7'd2) pix_d[cap_idx[5:0]] = IROM_Q;
        if (cnt_q == 7'd65) begin
          cnt_d  = 7'd0;
          busy_d = 1'b0;
        end
      end
      // busy stays high through the done cycle and drops on the following edge
      S_IDLE: begin
        if (accept) begin
          cmd_d  = cmd;
          busy_d = 1'b1;
          cnt_d  = 7'd0;
        end else begin
          busy_d = 1'b0;
        end
      end
      S_EXEC: begin
        busy_d = 1'b0;
        case (cmd_q)
          4'd1: if (py_q > 3'd1) py_d = py_q - 3'd1;
          4'd2: if (py_q < 3'd7) py_d = py_q + 3'd1;
          4'd3: if (px_q > 3'd1) px_d = px_q - 3'd1;
          4'd4: if (px_q < 3'd7) px_d = px_q + 3'd1;
          4'd5: begin
            pix_d[a00] = win_avg;
            pix_d[a01] = win_avg;
            pix_d[a10] = win_avg;
            pix_d[a11] = win_avg;
          end
          4'd6: begin
            pix_d[a00] = pix_q[a10];
            pix_d[a10] = pix_q[a00];
            pix_d[a01] = pix_q[a11];
            pix_d[a11] = pix_q[a01];
          end
          4'd7: begin
            pix_d[a00] = pix_q[a01];
            pix_d[a01] = pix_q[a00];
            pix_d[a10] = pix_q[a11];
            pix_d[a11] = pix_q[a10];
          end
          default: ;
        endcase
      end
      S_WRITE: begin
        irb_rw_d = 1'b0;
        irb_a_d  = cnt_q[5:0];
        irb_d_d  = pix_q[cnt_q[5:0]];
        cnt_d    = cnt_q + 7'd1;
      end
      S_DONE: done_d = 1'b1;
      default: ;
    endcase
  end

  assign IROM_EN = irom_en_q;
  assign IROM_A  = irom_a_q;
  assign IRB_RW  = irb_rw_q;
  assign IRB_A   = irb_a_q;
  assign IRB_D   = irb_d_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_lcd_ctrl.sv
// Bench for lcd_ctrl: IROM/IRB models plus a 2-D image reference model.
module tb_lcd_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] cmd;
  logic       cmd_valid;
  logic [7:0] IROM_Q;
  logic       IROM_EN;
  logic [5:0] IROM_A;
  logic       IRB_RW;
  logic [7:0] IRB_D;
  logic [5:0] IRB_A;
  logic       busy;
  logic       done;

  always #5 clk = ~clk;

  lcd_ctrl dut (
    .clk(clk), .reset(reset), .cmd(cmd), .cmd_valid(cmd_valid), .IROM_Q(IROM_Q),
    .IROM_EN(IROM_EN), .IROM_A(IROM_A), .IRB_RW(IRB_RW), .IRB_D(IRB_D),
    .IRB_A(IRB_A), .busy(busy), .done(done)
  );

  logic [7:0] rom [64];
  logic [7:0] irb [64];

  always @(posedge clk) if (!IROM_EN) IROM_Q <= rom[IROM_A];
  always @(posedge clk) if (!IRB_RW) irb[IRB_A] <= IRB_D;

  int checks = 0;
  int errors = 0;

  // reference image indexed [row][col], operation point (rx, ry)
  logic [7:0] ref_img [8][8];
  int rx, ry;

  function automatic void model_reset();
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) ref_img[r][c] = rom[r*8+c];
    rx = 4;
    ry = 4;
  endfunction

  function automatic void model_cmd(input int c);
    int s;
    logic [7:0] t;
    case (c)
      1: ry = (ry - 1 < 1) ? 1 : ry - 1;
      2: ry = (ry + 1 > 7) ? 7 : ry + 1;
      3: rx = (rx - 1 < 1) ? 1 : rx - 1;
      4: rx = (rx + 1 > 7) ? 7 : rx + 1;
      5: begin
        s = ref_img[ry-1][rx-1] + ref_img[ry-1][rx] + ref_img[ry][rx-1] + ref_img[ry][rx];
        s = s / 4;
        ref_img[ry-1][rx-1] = s[7:0];
        ref_img[ry-1][rx]   = s[7:0];
        ref_img[ry][rx-1]   = s[7:0];
        ref_img[ry][rx]     = s[7:0];
      end
      6: for (int cc = rx - 1; cc <= rx; cc++) begin
        t = ref_img[ry-1][cc];
        ref_img[ry-1][cc] = ref_img[ry][cc];
        ref_img[ry][cc] = t;
      end
      7: for (int rr = ry - 1; rr <= ry; rr++) begin
        t = ref_img[rr][rx-1];
        ref_img[rr][rx-1] = ref_img[rr][rx];
        ref_img[rr][rx] = t;
      end
      default: ;
    endcase
  endfunction

  task automatic reset_load(output int load_cyc, output int en_cyc, output bit seq_ok, output bit ok);
    cmd_valid = 1'b0;
    cmd = 4'd0;
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    load_cyc = 0;
    en_cyc = 0;
    seq_ok = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      load_cyc++;
      if (!IROM_EN) begin
        if (IROM_A != en_cyc[5:0]) seq_ok = 1'b0;
        en_cyc++;
      end
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
    model_reset();
  endtask

  task automatic send_cmd(input logic [3:0] c, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
    if (ok) begin
      cmd = c;
      cmd_valid = 1'b1;
      @(negedge clk);
      cmd_valid = 1'b0;
    end
  endtask

  task automatic do_write(output int done_cnt, output int wr_cyc, output bit ok);
    bit sent;
    done_cnt = 0;
    wr_cyc = 0;
    ok = 1'b0;
    send_cmd(4'd0, sent);
    if (!sent) return;
    for (int i = 0; i < 300; i++) begin
      if (done) done_cnt++;
      if (!IRB_RW) wr_cyc++;
      if (!busy) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    int lc, ec;
    bit sq, ok;
    cmd_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks += 8;
    if (busy !== 1'b1)    begin errors++; $display("FAIL rst_busy: got %b expected 1", busy); end
    if (done !== 1'b0)    begin errors++; $display("FAIL rst_done: got %b expected 0", done); end
    if (IROM_EN !== 1'b1) begin errors++; $display("FAIL rst_irom_en: got %b expected 1", IROM_EN); end
    if (IROM_A !== 6'd0)  begin errors++; $display("FAIL rst_irom_a: got %0d expected 0", IROM_A); end
    if (IRB_RW !== 1'b1)  begin errors++; $display("FAIL rst_irb_rw: got %b expected 1", IRB_RW); end
    if (IRB_A !== 6'd0)   begin errors++; $display("FAIL rst_irb_a: got %0d expected 0", IRB_A); end
    if (IRB_D !== 8'd0)   begin errors++; $display("FAIL rst_irb_d: got %0d expected 0", IRB_D); end
    @(negedge clk);
    if (busy !== 1'b1)    begin errors++; $display("FAIL rst_busy_hold: got %b expected 1", busy); end
    reset_load(lc, ec, sq, ok);
    checks += 5;
    if (!ok) begin errors++; $display("FAIL load_timeout: busy never fell, got %0d cycles", lc); end
    if (lc < 60 || lc > 72) begin errors++; $display("FAIL load_len: got %0d cycles expected about 65", lc); end
    if (ec != 64) begin errors++; $display("FAIL load_en_cycles: got %0d expected 64", ec); end
    if (!sq) begin errors++; $display("FAIL load_addr_seq: got out-of-order IROM_A expected 0..63"); end
    if (done !== 1'b0) begin errors++; $display("FAIL load_done: got %b expected 0", done); end
  endtask

  task automatic test_load_write();
    int dc, wc;
    bit ok;
    do_write(dc, wc, ok);
    checks += 3;
    if (!ok) begin errors++; $display("FAIL lw_timeout: got busy stuck expected release"); end
    if (dc != 1) begin errors++; $display("FAIL lw_done_pulses: got %0d expected 1", dc); end
    if (wc != 64) begin errors++; $display("FAIL lw_write_cycles: got %0d expected 64", wc); end
    for (int k = 0; k < 64; k++) begin
      checks++;
      if (irb[k] !== k[7:0]) begin errors++; $display("FAIL lw_pix%0d: got %0d expected %0d", k, irb[k], k); end
    end
  endtask

  task automatic test_average();
    int lc, ec, dc, wc;
    bit sq, ok, s;
    reset_load(lc, ec, sq, ok);
    send_cmd(4'd5, s);
    model_cmd(5);
    do_write(dc, wc, ok);
    checks += 6;
    if (!(s && ok)) begin errors++; $display("FAIL avg_timeout: got stall expected completion"); end
    if (dc != 1) begin errors++; $display("FAIL avg_done: got %0d expected 1", dc); end
    if (irb[27] !== 8'd31) begin errors++; $display("FAIL avg_p27: got %0d expected 31", irb[27]); end
    if (irb[28] !== 8'd31) begin errors++; $display("FAIL avg_p28: got %0d expected 31", irb[28]); end
    if (irb[35] !== 8'd31) begin errors++; $display("FAIL avg_p35: got %0d expected 31", irb[35]); end
    if (irb[36] !== 8'd31) begin errors++; $display("FAIL avg_p36: got %0d expected 31", irb[36]); end
    for (int k = 0; k < 64; k++) begin
      checks++;
      if (irb[k] !== ref_img[k/8][k%8]) begin errors++; $display("FAIL avg_pix%0d: got %0d expected %0d", k, irb[k], ref_img[k/8][k%8]); end
    end
  endtask

  task automatic test_mirror();
    int lc, ec, dc, wc;
    bit sq, ok, s;
    reset_load(lc, ec, sq, ok);
    send_cmd(4'd6, s);
    model_cmd(6);
    do_write(dc, wc, ok);
    checks += 5;
    if (!(s && ok)) begin errors++; $display("FAIL mx_timeout: got stall expected completion"); end
    if (irb[27] !== 8'd35) begin errors++; $display("FAIL mx_p27: got %0d expected 35", irb[27]); end
    if (irb[35] !== 8'd27) begin errors++; $display("FAIL mx_p35: got %0d expected 27", irb[35]); end
    if (irb[28] !== 8'd36) begin errors++; $display("FAIL mx_p28: got %0d expected 36", irb[28]); end
    if (irb[36] !== 8'd28) begin errors++; $display("FAIL mx_p36: got %0d expected 28", irb[36]); end
    for (int k = 0; k < 64; k++) begin
      checks++;
      if (irb[k] !== ref_img[k/8][k%8]) begin errors++; $display("FAIL mx_pix%0d: got %0d expected %0d", k, irb[k], ref_img[k/8][k%8]); end
    end
    reset_load(lc, ec, sq, ok);
    send_cmd(4'd7, s);
    model_cmd(7);
    do_write(dc, wc, ok);
    checks += 5;
    if (!(s && ok)) begin errors++; $display("FAIL my_timeout: got stall expected completion"); end
    if (irb[27] !== 8'd28) begin errors++; $display("FAIL my_p27: got %0d expected 28", irb[27]); end
    if (irb[28] !== 8'd27) begin errors++; $display("FAIL my_p28: got %0d expected 27", irb[28]); end
    if (irb[35] !== 8'd36) begin errors++; $display("FAIL my_p35: got %0d expected 36", irb[35]); end
    if (irb[36] !== 8'd35) begin errors++; $display("FAIL my_p36: got %0d expected 35", irb[36]); end
    for (int k = 0; k < 64; k++) begin
      checks++;
      if (irb[k] !== ref_img[k/8][k%8]) begin errors++; $display("FAIL my_pix%0d: got %0d expected %0d", k, irb[k], ref_img[k/8][k%8]); end
    end
  endtask

  task automatic test_saturate();
    int lc, ec, dc, wc;
    bit sq, ok, s, all_s;
    reset_load(lc, ec, sq, ok);
    all_s = 1'b1;
    for (int i = 0; i < 5; i++) begin send_cmd(4'd1, s); all_s &= s; model_cmd(1); end
    for (int i = 0; i < 5; i++) begin send_cmd(4'd3, s); all_s &= s; model_cmd(3); end
    send_cmd(4'd5, s);
    all_s &= s;
    model_cmd(5);
    do_write(dc, wc, ok);
    checks += 5;
    if (!(all_s && ok)) begin errors++; $display("FAIL sat_timeout: got stall expected completion"); end
    if (irb[0] !== 8'd4) begin errors++; $display("FAIL sat_p0: got %0d expected 4", irb[0]); end
    if (irb[1] !== 8'd4) begin errors++; $display("FAIL sat_p1: got %0d expected 4", irb[1]); end
    if (irb[8] !== 8'd4) begin errors++; $display("FAIL sat_p8: got %0d expected 4", irb[8]); end
    if (irb[9] !== 8'd4) begin errors++; $display("FAIL sat_p9: got %0d expected 4", irb[9]); end
    for (int k = 0; k < 64; k++) begin
      checks++;
      if (irb[k] !== ref_img[k/8][k%8]) begin errors++; $display("FAIL sat_pix%0d: got %0d expected %0d", k, irb[k], ref_img[k/8][k%8]); end
    end
  endtask

  task automatic test_busy_timing();
    int lc, ec, dc, wc;
    bit sq, ok, s;
    reset_load(lc, ec, sq, ok);
    send_cmd(4'd4, s);
    model_cmd(4);
    checks += 2;
    if (busy !== 1'b1) begin errors++; $display("FAIL bt_busy_set: got %b expected 1", busy); end
    // a strobe presented during the busy cycle must be dropped
    cmd = 4'd2;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    if (busy !== 1'b0) begin errors++; $display("FAIL bt_busy_clear: got %b expected 0", busy); end
    send_cmd(4'd5, s);
    model_cmd(5);
    do_write(dc, wc, ok);
    checks++;
    if (!(s && ok)) begin errors++; $display("FAIL bt_timeout: got stall expected completion"); end
    for (int k = 0; k < 64; k++) begin
      checks++;
      if (irb[k] !== ref_img[k/8][k%8]) begin errors++; $display("FAIL bt_pix%0d: got %0d expected %0d", k, irb[k], ref_img[k/8][k%8]); end
    end
  endtask

  task automatic test_back_to_back();
    int lc, ec, dc, wc, idx, cyc;
    bit sq, ok, fin;
    logic [3:0] list [40];
    reset_load(lc, ec, sq, ok);
    for (int i = 0; i < 40; i++) list[i] = 4'($urandom_range(1, 15));
    idx = 0;
    cyc = 0;
    fin = 1'b0;
    for (int i = 0; i < 400 && !fin; i++) begin
      @(negedge clk);
      cyc++;
      if (!busy) begin
        if (idx < 40) begin
          cmd = list[idx];
          cmd_valid = 1'b1;
          model_cmd(int'(list[idx]));
          idx++;
        end else begin
          cmd_valid = 1'b0;
          fin = 1'b1;
        end
      end
    end
    checks += 2;
    if (!fin) begin errors++; $display("FAIL b2b_timeout: got %0d cmds issued expected 40", idx); end
    if (cyc != 81) begin errors++; $display("FAIL b2b_cycles: got %0d expected 81", cyc); end
    do_write(dc, wc, ok);
    checks += 2;
    if (!ok) begin errors++; $display("FAIL b2b_write_timeout: got stall expected completion"); end
    if (dc != 1) begin errors++; $display("FAIL b2b_done: got %0d expected 1", dc); end
    for (int k = 0; k < 64; k++) begin
      checks++;
      if (irb[k] !== ref_img[k/8][k%8]) begin errors++; $display("FAIL b2b_pix%0d: got %0d expected %0d", k, irb[k], ref_img[k/8][k%8]); end
    end
  endtask

  task automatic test_reset_mid_write();
    int lc, ec, dc, wc;
    bit sq, ok, s;
    reset_load(lc, ec, sq, ok);
    send_cmd(4'd2, s);
    send_cmd(4'd4, s);
    send_cmd(4'd5, s);
    send_cmd(4'd0, s);
    repeat (20) @(negedge clk);
    checks++;
    if (IRB_RW !== 1'b0) begin errors++; $display("FAIL rmw_writing: got IRB_RW=%b expected 0", IRB_RW); end
    reset = 1'b1;
    @(negedge clk);
    checks += 3;
    if (busy !== 1'b1)   begin errors++; $display("FAIL rmw_busy: got %b expected 1", busy); end
    if (IRB_RW !== 1'b1) begin errors++; $display("FAIL rmw_irb_rw: got %b expected 1", IRB_RW); end
    if (done !== 1'b0)   begin errors++; $display("FAIL rmw_done: got %b expected 0", done); end
    reset_load(lc, ec, sq, ok);
    checks += 2;
    if (!ok) begin errors++; $display("FAIL rmw_reload: got no load completion expected busy low"); end
    if (ec != 64) begin errors++; $display("FAIL rmw_en_cycles: got %0d expected 64", ec); end
    do_write(dc, wc, ok);
    for (int k = 0; k < 64; k++) begin
      checks++;
      if (irb[k] !== k[7:0]) begin errors++; $display("FAIL rmw_pix%0d: got %0d expected %0d", k, irb[k], k); end
    end
    send_cmd(4'd5, s);
    model_cmd(5);
    do_write(dc, wc, ok);
    checks += 2;
    if (irb[27] !== 8'd31) begin errors++; $display("FAIL rmw_point_p27: got %0d expected 31", irb[27]); end
    if (irb[36] !== ref_img[4][4]) begin errors++; $display("FAIL rmw_point_p36: got %0d expected %0d", irb[36], ref_img[4][4]); end
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    cmd = 4'd0;
    cmd_valid = 1'b0;
    for (int k = 0; k < 64; k++) rom[k] = k[7:0];
    test_reset();
    test_load_write();
    test_average();
    test_mirror();
    test_saturate();
    test_busy_timing();
    test_back_to_back();
    test_reset_mid_write();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
